// File: rtl/spi_fifo_ctrl.sv
// SPI FIFO controller: buffers CPU bytes in a TX FIFO, feeds them one at a
// time to the SPI byte engine, collects replies in an RX FIFO and drives the
// device chip-select with setup/hold spacing and multi-byte frames.
module spi_fifo_ctrl #(
   parameter int DEPTH       = 8,
   parameter int XFER_CYCLES = 20,
   parameter int CS_SETUP    = 2,
   parameter int CS_HOLD     = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [7:0]               wr_data,
   input  logic                     rd_en,
   output logic [7:0]               rd_data,
   input  logic                     cs_keep,
   input  logic                     flag_clr,
   output logic                     tx_full,
   output logic                     tx_empty,
   output logic                     rx_empty,
   output logic [$clog2(DEPTH):0]   rx_count,
   output logic                     busy,
   output logic                     tx_ovf,
   output logic                     rx_ovf,
   output logic                     spi_send,
   output logic [7:0]               spi_dout,
   input  logic [7:0]               spi_din,
   output logic                     spi_cs_n
);

   localparam int AW   = $clog2(DEPTH);
   localparam int CMAX = (XFER_CYCLES > CS_SETUP)
                         ? ((XFER_CYCLES > CS_HOLD) ? XFER_CYCLES : CS_HOLD)
                         : ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
   localparam int CW   = $clog2(CMAX + 1);

   localparam logic [AW:0]   P_ONE   = (AW + 1)'(1);
   localparam logic [CW-1:0] C_ONE   = CW'(1);
   localparam logic [CW-1:0] XFER_L  = CW'(XFER_CYCLES);
   localparam logic [CW-1:0] SETUP_L = CW'(CS_SETUP);
   localparam logic [CW-1:0] HOLD_L  = CW'(CS_HOLD);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SETUP   = 3'd1,
      S_LAUNCH  = 3'd2,
      S_WAIT    = 3'd3,
      S_CAPTURE = 3'd4,
      S_HOLD    = 3'd5
   } state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic            cs_n_q;
   logic            send_q;
   logic [7:0]      dout_q;

   // ---------------------------------------------------------------- TX FIFO
   logic [7:0]  tx_mem_q [DEPTH];
   logic [AW:0] tx_wp_q, tx_rp_q;
   logic [AW:0] tx_wp_d, tx_rp_d;
   logic        tx_push, tx_pop;

   assign tx_empty = (tx_wp_q == tx_rp_q);
   assign tx_full  = (tx_wp_q[AW] != tx_rp_q[AW]) &&
                     (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);

   // The engine pop happens on the edge that enters LAUNCH so the byte and
   // the send pulse are both registered outputs during the LAUNCH cycle.
   // SETUP only ever runs with a non-empty TX FIFO, so no empty check there.
   assign tx_pop = ((state_q == S_SETUP) && (cnt_q == C_ONE)) ||
                   ((state_q == S_IDLE) && !tx_empty && !cs_n_q) ||
                   ((state_q == S_CAPTURE) && !tx_empty);

   // A same-cycle pop frees the slot, so a full FIFO still accepts the write.
   assign tx_push = wr_en && (!tx_full || tx_pop);
   assign tx_wp_d = tx_push ? (tx_wp_q + P_ONE) : tx_wp_q;
   assign tx_rp_d = tx_pop  ? (tx_rp_q + P_ONE) : tx_rp_q;

   // TX storage; contents need no reset since occupancy comes from pointers
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem_q[tx_wp_q[AW-1:0]] <= wr_data;
   end

   // TX pointers, wrapping modulo 2*DEPTH
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_wp_q <= '0;
         tx_rp_q <= '0;
      end else begin
         tx_wp_q <= tx_wp_d;
         tx_rp_q <= tx_rp_d;
      end
   end

   // ---------------------------------------------------------------- RX FIFO
   logic [7:0]  rx_mem_q [DEPTH];
   logic [AW:0] rx_wp_q, rx_rp_q;
   logic [AW:0] rx_wp_d, rx_rp_d;
   logic        rx_full, rx_pop, rx_cap, rx_push;

   assign rx_empty = (rx_wp_q == rx_rp_q);
   assign rx_full  = (rx_wp_q[AW] != rx_rp_q[AW]) &&
                     (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);
   assign rx_count = rx_wp_q - rx_rp_q;
   assign rd_data  = rx_empty ? 8'h00 : rx_mem_q[rx_rp_q[AW-1:0]];

   assign rx_pop  = rd_en && !rx_empty;
   assign rx_cap  = (state_q == S_CAPTURE);
   assign rx_push = rx_cap && (!rx_full || rx_pop);
   assign rx_wp_d = rx_push ? (rx_wp_q + P_ONE) : rx_wp_q;
   assign rx_rp_d = rx_pop  ? (rx_rp_q + P_ONE) : rx_rp_q;

   // RX storage written with the engine's byte during CAPTURE
   always_ff @(posedge clk) begin
      if (rx_push) rx_mem_q[rx_wp_q[AW-1:0]] <= spi_din;
   end

   // RX pointers, wrapping modulo 2*DEPTH
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_wp_q <= '0;
         rx_rp_q <= '0;
      end else begin
         rx_wp_q <= rx_wp_d;
         rx_rp_q <= rx_rp_d;
      end
   end

   // ------------------------------------------------------------ sticky flags
   logic tx_ovf_q, rx_ovf_q;
   logic tx_ovf_d, rx_ovf_d;

   // Clear first, then a fresh overflow in the same cycle re-sets the flag
   always_comb begin
      tx_ovf_d = flag_clr ? 1'b0 : tx_ovf_q;
      rx_ovf_d = flag_clr ? 1'b0 : rx_ovf_q;
      if (wr_en && !tx_push) tx_ovf_d = 1'b1;
      if (rx_cap && !rx_push) rx_ovf_d = 1'b1;
   end

   // Overflow flag registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_ovf_q <= 1'b0;
         rx_ovf_q <= 1'b0;
      end else begin
         tx_ovf_q <= tx_ovf_d;
         rx_ovf_q <= rx_ovf_d;
      end
   end

   assign tx_ovf = tx_ovf_q;
   assign rx_ovf = rx_ovf_q;

   // --------------------------------------------------------------------- FSM
   // Frame sequencer with registered chip-select, send pulse and data byte
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         cs_n_q  <= 1'b1;
         send_q  <= 1'b0;
         dout_q  <= 8'h00;
      end else begin
         send_q <= 1'b0;
         if (tx_pop) begin
            dout_q  <= tx_mem_q[tx_rp_q[AW-1:0]];
            send_q  <= 1'b1;
            state_q <= S_LAUNCH;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (!tx_empty) begin
                     // CS is high here; a kept-low CS would have launched
                     cs_n_q  <= 1'b0;
                     cnt_q   <= SETUP_L;
                     state_q <= S_SETUP;
                  end else if (!cs_n_q && !cs_keep) begin
                     cnt_q   <= HOLD_L;
                     state_q <= S_HOLD;
                  end
               end
               S_SETUP: cnt_q <= cnt_q - C_ONE;
               S_LAUNCH: begin
                  cnt_q   <= XFER_L;
                  state_q <= S_WAIT;
               end
               S_WAIT: begin
                  if (cnt_q == C_ONE) state_q <= S_CAPTURE;
                  else                cnt_q   <= cnt_q - C_ONE;
               end
               S_CAPTURE: begin
                  // Back-to-back case is handled by tx_pop above
                  if (cs_keep) begin
                     state_q <= S_IDLE;
                  end else begin
                     cnt_q   <= HOLD_L;
                     state_q <= S_HOLD;
                  end
               end
               S_HOLD: begin
                  // New TX bytes wait for the hold to finish and a new SETUP
                  if (cnt_q == C_ONE) begin
                     cs_n_q  <= 1'b1;
                     state_q <= S_IDLE;
                  end else begin
                     cnt_q <= cnt_q - C_ONE;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign spi_send = send_q;
   assign spi_dout = dout_q;
   assign spi_cs_n = cs_n_q;

endmodule

// File: tb/tb_spi_fifo_ctrl.sv
// Bench for spi_fifo_ctrl: directed stimulus, an event-schedule reference
// model compared every cycle, plus hand-computed literal checks.
module tb_spi_fifo_ctrl;

   localparam int DEPTH = 8;
   localparam int XFER  = 20;
   localparam int SETUP = 2;
   localparam int HOLD  = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       wr_en = 1'b0, rd_en = 1'b0, cs_keep = 1'b0, flag_clr = 1'b0;
   logic [7:0] wr_data = 8'h00, spi_din = 8'h00;
   logic [7:0] rd_data, spi_dout;
   logic       tx_full, tx_empty, rx_empty, busy, tx_ovf, rx_ovf;
   logic       spi_send, spi_cs_n;
   logic [3:0] rx_count;

   spi_fifo_ctrl #(.DEPTH(DEPTH), .XFER_CYCLES(XFER), .CS_SETUP(SETUP),
                   .CS_HOLD(HOLD)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(rd_data), .cs_keep(cs_keep), .flag_clr(flag_clr),
      .tx_full(tx_full), .tx_empty(tx_empty), .rx_empty(rx_empty),
      .rx_count(rx_count), .busy(busy), .tx_ovf(tx_ovf), .rx_ovf(rx_ovf),
      .spi_send(spi_send), .spi_dout(spi_dout), .spi_din(spi_din),
      .spi_cs_n(spi_cs_n));

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit chk_en  = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   // Engine stand-in: replies with the sent byte XOR 0x99
   initial forever begin
      @(negedge clk);
      spi_din = spi_dout ^ 8'h99;
   end

   // ---------------------------------------------------------------- model
   // Frame timing kept as absolute edge numbers of the next send, capture
   // and chip-select rise; no pending event means the controller is idle.
   int         mq_tx[$];
   logic [7:0] mq_rx[$];
   bit         m_cs_n = 1'b1, m_send = 1'b0, m_txovf = 1'b0, m_rxovf = 1'b0;
   logic [7:0] m_dout = 8'h00;
   int         t_send = -1, t_cap = -1, t_rise = -1;

   task automatic model_reset();
      mq_tx.delete(); mq_rx.delete();
      m_cs_n = 1'b1; m_send = 1'b0; m_dout = 8'h00;
      m_txovf = 1'b0; m_rxovf = 1'b0;
      t_send = -1; t_cap = -1; t_rise = -1;
   endtask

   task automatic model_step(input int e);
      bit send_now = 1'b0;
      bit cap_now  = 1'b0;
      int pre_tx   = mq_tx.size();
      if (t_cap == e) begin
         t_cap = -1; cap_now = 1'b1;
         if (pre_tx > 0)    send_now = 1'b1;
         else if (!cs_keep) t_rise = e + HOLD;
      end else if (t_send == e) begin
         t_send = -1; send_now = 1'b1;
      end else if (t_rise == e) begin
         t_rise = -1; m_cs_n = 1'b1;
      end else if (t_send < 0 && t_cap < 0 && t_rise < 0) begin
         if (pre_tx > 0) begin
            if (m_cs_n) begin m_cs_n = 1'b0; t_send = e + SETUP; end
            else send_now = 1'b1;
         end else if (!m_cs_n && !cs_keep) begin
            t_rise = e + HOLD;
         end
      end
      if (cap_now) begin
         if (rd_en && mq_rx.size() > 0) void'(mq_rx.pop_front());
         if (mq_rx.size() < DEPTH) mq_rx.push_back(m_dout ^ 8'h99);
         else m_rxovf = 1'b1;
      end else if (rd_en && mq_rx.size() > 0) begin
         void'(mq_rx.pop_front());
      end
      m_send = send_now;
      if (send_now) begin
         m_dout = 8'(mq_tx.pop_front());
         t_cap  = e + XFER + 2;
      end
      if (flag_clr) begin m_txovf = 1'b0; m_rxovf = 1'b0; end
      if (cap_now && mq_rx.size() == DEPTH && m_rxovf == 1'b0 && flag_clr) begin
         // a drop in the clearing cycle must still leave the flag set
      end
      if (wr_en) begin
         if (mq_tx.size() < DEPTH) mq_tx.push_back(int'(wr_data));
         else m_txovf = 1'b1;
      end
   endtask

   // Model clocking; captures that were dropped re-set rx_ovf after a clear
   bit cap_drop;
   initial forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else begin
         cyc++;
         cap_drop = (t_cap == cyc) && (mq_rx.size() == DEPTH) &&
                    !(rd_en && mq_rx.size() > 0);
         model_step(cyc);
         if (cap_drop) m_rxovf = 1'b1;
      end
   end

   // ---------------------------------------------------- compare + monitor
   int sends[$];
   int csfall_t = -1, csrise_t = -1, nfall = 0;
   bit prev_cs = 1'b1;

   initial forever begin
      @(negedge clk);
      if (rst && chk_en) begin
         chk("cs_n",     32'(spi_cs_n), 32'(m_cs_n));
         chk("send",     32'(spi_send), 32'(m_send));
         chk("dout",     32'(spi_dout), 32'(m_dout));
         chk("busy",     32'(busy),     32'(t_send >= 0 || t_cap >= 0 || t_rise >= 0));
         chk("tx_empty", 32'(tx_empty), 32'(mq_tx.size() == 0));
         chk("tx_full",  32'(tx_full),  32'(mq_tx.size() == DEPTH));
         chk("rx_empty", 32'(rx_empty), 32'(mq_rx.size() == 0));
         chk("rx_count", 32'(rx_count), 32'(mq_rx.size()));
         chk("rd_data",  32'(rd_data),  32'(mq_rx.size() > 0 ? mq_rx[0] : 8'h00));
         chk("tx_ovf",   32'(tx_ovf),   32'(m_txovf));
         chk("rx_ovf",   32'(rx_ovf),   32'(m_rxovf));
         if (spi_send) sends.push_back(cyc);
         if (prev_cs && !spi_cs_n) begin csfall_t = cyc; nfall++; end
         if (!prev_cs && spi_cs_n) csrise_t = cyc;
         prev_cs = spi_cs_n;
      end else begin
         prev_cs = 1'b1;
      end
   end

   // ---------------------------------------------------------- stimulus
   task automatic wait_idle(input int budget);
      int n = 0;
      while ((busy || !tx_empty) && n < budget) begin @(negedge clk); n++; end
      chk("wait_idle_timeout", 32'(n < budget), 32'd1);
   endtask

   task automatic wait_send(input int budget);
      int n = 0;
      while (sends.size() == 0 && n < budget) begin @(negedge clk); n++; end
      chk("wait_send_timeout", 32'(n < budget), 32'd1);
   endtask

   task automatic wait_rx(input int budget);
      int n = 0;
      while (rx_empty && n < budget) begin @(negedge clk); n++; end
      chk("wait_rx_timeout", 32'(n < budget), 32'd1);
   endtask

   task automatic write1(input logic [7:0] b);
      wr_en = 1'b1; wr_data = b;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic read1(input string nm, input logic [7:0] exp);
      chk(nm, 32'(rd_data), 32'(exp));
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
   endtask

   initial begin
      int c, d, nf;
      logic [7:0] e;
      // reset state
      repeat (2) @(negedge clk);
      chk("rst_cs_n",     32'(spi_cs_n), 32'd1);
      chk("rst_send",     32'(spi_send), 32'd0);
      chk("rst_dout",     32'(spi_dout), 32'd0);
      chk("rst_rd_data",  32'(rd_data),  32'd0);
      chk("rst_busy",     32'(busy),     32'd0);
      chk("rst_tx_empty", 32'(tx_empty), 32'd1);
      chk("rst_rx_empty", 32'(rx_empty), 32'd1);
      chk("rst_tx_full",  32'(tx_full),  32'd0);
      chk("rst_rx_count", 32'(rx_count), 32'd0);
      chk("rst_ovf",      32'({tx_ovf, rx_ovf}), 32'd0);
      rst = 1'b1; chk_en = 1'b1;
      @(negedge clk);

      // single byte
      sends.delete();
      c = cyc;
      write1(8'hA5);
      wait_idle(100);
      chk("single_nsend",    32'(sends.size()), 32'd1);
      chk("single_csfall",   32'(csfall_t - c), 32'd2);
      chk("single_sendtime", 32'(sends[0] - c), 32'd4);
      chk("single_setup",    32'(sends[0] - csfall_t), 32'd2);
      chk("single_dout",     32'(spi_dout), 32'hA5);
      chk("single_rxcnt",    32'(rx_count), 32'd1);
      chk("single_csrise",   32'(csrise_t - sends[0]), 32'd24);
      read1("single_rd", 8'h3C);
      rd_en = 1'b1; @(negedge clk); rd_en = 1'b0;   // pop while empty: ignored
      chk("empty_pop_cnt", 32'(rx_count), 32'd0);

      // burst of three
      sends.delete(); nf = nfall;
      write1(8'h01); write1(8'h02); write1(8'h03);
      wait_idle(200);
      chk("burst_nsend", 32'(sends.size()), 32'd3);
      chk("burst_gap1",  32'(sends[1] - sends[0]), 32'd22);
      chk("burst_gap2",  32'(sends[2] - sends[1]), 32'd22);
      chk("burst_1fall", 32'(nfall - nf), 32'd1);
      read1("burst_rd0", 8'h98); read1("burst_rd1", 8'h9B); read1("burst_rd2", 8'h9A);

      // TX overflow while the engine waits, then RX overflow from the drain
      sends.delete();
      write1(8'h10);
      wait_send(20);
      for (int i = 0; i < 9; i++) write1(8'h20 + 8'(i));
      chk("txovf_full", 32'(tx_full), 32'd1);
      chk("txovf_flag", 32'(tx_ovf),  32'd1);
      flag_clr = 1'b1; @(negedge clk); flag_clr = 1'b0;
      chk("txovf_clr",  32'(tx_ovf),  32'd0);
      wait_idle(400);
      chk("rxovf_cnt",  32'(rx_count), 32'd8);
      chk("rxovf_flag", 32'(rx_ovf),   32'd1);
      read1("rxovf_rd0", 8'h89);
      read1("rxovf_rd1", 8'hB9);
      for (int i = 2; i < 8; i++) begin
         e = (8'h20 + 8'(i - 1)) ^ 8'h99;
         read1("rxovf_rdn", e);
      end
      flag_clr = 1'b1; @(negedge clk); flag_clr = 1'b0;

      // alternating write/read to wrap both pointer sets
      for (int i = 0; i < 20; i++) begin
         write1(8'h40 + 8'(i));
         wait_rx(60);
         e = (8'h40 + 8'(i)) ^ 8'h99;
         read1("wrap_rd", e);
      end
      wait_idle(100);

      // cs_keep frame
      cs_keep = 1'b1;
      write1(8'h55); write1(8'h66);
      wait_idle(200);
      chk("keep_cs_low", 32'(spi_cs_n), 32'd0);
      chk("keep_busy",   32'(busy),     32'd0);
      sends.delete(); nf = nfall;
      c = cyc;
      write1(8'h77);
      wait_send(20);
      chk("keep_nosetup", 32'(sends[0] - c), 32'd2);
      chk("keep_nofall",  32'(nfall - nf), 32'd0);
      wait_idle(100);
      d = cyc;
      cs_keep = 1'b0;
      repeat (6) @(negedge clk);
      chk("keep_rise", 32'(csrise_t - d), 32'd3);
      read1("keep_rd0", 8'hCC); read1("keep_rd1", 8'hFF); read1("keep_rd2", 8'hEE);

      // reset in the middle of WAIT
      sends.delete();
      write1(8'h99); write1(8'h98);
      wait_send(20);
      repeat (5) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst_cs_n",     32'(spi_cs_n), 32'd1);
      chk("arst_send",     32'(spi_send), 32'd0);
      chk("arst_tx_empty", 32'(tx_empty), 32'd1);
      chk("arst_rx_count", 32'(rx_count), 32'd0);
      chk("arst_busy",     32'(busy),     32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_busy",  32'(busy),     32'd0);
      chk("post_cs_n",  32'(spi_cs_n), 32'd1);
      chk("post_empty", 32'(tx_empty), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
